// File: rtl/audio_pkg.sv
// Shared audio sample types and constants for the looper datapath.
package audio_pkg;

    localparam int DATA_WIDTH = 24;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        PLAY,
        FADE_OUT
    } fade_state_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam int      GAIN_UNITY = 8;

endpackage

// File: rtl/loop_mixer_if.sv
// Sample-rate bus between the looper, the mixer and the codec output path.
interface loop_mixer_if #(
    parameter int GAIN_WIDTH = 4
);
    import audio_pkg::*;

    logic                  sample_valid;
    sample_t               live_in;
    sample_t               loop_in;
    logic                  loop_enable;
    logic [GAIN_WIDTH-1:0] loop_gain;
    sample_t               out;
    logic                  out_valid;

    modport master (
        output sample_valid, live_in, loop_in, loop_enable, loop_gain,
        input  out, out_valid
    );

    modport slave (
        input  sample_valid, live_in, loop_in, loop_enable, loop_gain,
        output out, out_valid
    );

endinterface

// File: rtl/audio_sat_add.sv
// Full-width signed add of a sample and a wider term, clamped back to sample_t.
module audio_sat_add
    import audio_pkg::*;
#(
    parameter int B_WIDTH = 32
) (
    input  sample_t                    a_i,
    input  logic signed [B_WIDTH-1:0]  b_i,
    output sample_t                    y_o
);

    localparam int SW = ((B_WIDTH > DATA_WIDTH) ? B_WIDTH : DATA_WIDTH) + 1;

    localparam logic signed [SW-1:0] MAX_W = {{(SW-DATA_WIDTH){1'b0}}, SAMPLE_MAX};
    localparam logic signed [SW-1:0] MIN_W = {{(SW-DATA_WIDTH){1'b1}}, SAMPLE_MIN};

    function automatic sample_t sat(input logic signed [SW-1:0] v);
        if (v > MAX_W) begin
            return SAMPLE_MAX;
        end else if (v < MIN_W) begin
            return SAMPLE_MIN;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    logic signed [SW-1:0] a_x;
    logic signed [SW-1:0] b_x;
    logic signed [SW-1:0] sum;

    assign a_x = {{(SW-DATA_WIDTH){a_i[DATA_WIDTH-1]}}, a_i};
    assign b_x = {{(SW-B_WIDTH){b_i[B_WIDTH-1]}}, b_i};
    assign sum = a_x + b_x;
    assign y_o = sat(sum);

endmodule

// File: rtl/loop_mixer.sv
// Mixes live input with faded, gain-scaled loop playback; fixed two-clock latency.
module loop_mixer
    import audio_pkg::*;
#(
    parameter int RAMP_BITS  = 4,
    parameter int GAIN_WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    loop_mixer_if.slave  bus
);

    localparam int CW    = RAMP_BITS + 1;
    localparam int P1W   = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int PW    = P1W + CW + 1;
    localparam int SHIFT = RAMP_BITS + $clog2(GAIN_UNITY);
    localparam logic [CW-1:0] COEF_MAX = {1'b1, {RAMP_BITS{1'b0}}};

    fade_state_t     state_q, state_d;
    logic [CW-1:0]   coef_q, coef_d;
    logic [CW-1:0]   coef_inc, coef_dec;

    logic                     vld_p1_q;
    sample_t                  live_p1_q;
    logic [CW-1:0]            coef_p1_q;
    logic signed [P1W-1:0]    prod_p1_q;
    logic signed [P1W-1:0]    loop_x, gain_x;

    logic signed [PW-1:0]     p1_x, coef_x, prod_p2, scaled_p2;
    sample_t                  sum_p2;
    sample_t                  out_p2_q;
    logic                     vld_p2_q;

    // Ramp steps saturate at the ends so a reversal at either limit cannot wrap.
    always_comb begin
        coef_inc = (coef_q == COEF_MAX) ? COEF_MAX : coef_q + 1'b1;
        coef_dec = (coef_q == '0) ? '0 : coef_q - 1'b1;
        state_d  = state_q;
        coef_d   = coef_q;
        if (bus.sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.loop_enable) begin
                        state_d = FADE_IN;
                        coef_d  = coef_inc;
                    end else begin
                        coef_d  = '0;
                    end
                end
                FADE_IN: begin
                    if (!bus.loop_enable) begin
                        state_d = FADE_OUT;
                        coef_d  = coef_dec;
                    end else begin
                        coef_d  = coef_inc;
                        if (coef_inc == COEF_MAX) state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (!bus.loop_enable) begin
                        state_d = FADE_OUT;
                        coef_d  = coef_dec;
                    end else begin
                        coef_d  = COEF_MAX;
                    end
                end
                FADE_OUT: begin
                    if (bus.loop_enable) begin
                        state_d = FADE_IN;
                        coef_d  = coef_inc;
                    end else begin
                        coef_d  = coef_dec;
                        if (coef_dec == '0) state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    coef_d  = '0;
                end
            endcase
        end
    end

    assign loop_x = {{(P1W-DATA_WIDTH){bus.loop_in[DATA_WIDTH-1]}}, bus.loop_in};
    assign gain_x = {{(P1W-GAIN_WIDTH){1'b0}}, bus.loop_gain};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            coef_q   <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            out_p2_q <= '0;
        end else begin
            state_q  <= state_d;
            coef_q   <= coef_d;
            vld_p1_q <= bus.sample_valid;
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) out_p2_q <= sum_p2;
        end
    end

    // ---- stage 1: capture live sample, pre-update coef and loop*gain ----
    always_ff @(posedge clk) begin
        if (bus.sample_valid) begin
            live_p1_q <= bus.live_in;
            coef_p1_q <= coef_q;
            prod_p1_q <= loop_x * gain_x;
        end
    end

    // ---- stage 2: fade scaling, floor shift, saturating mix ----
    assign p1_x      = {{(PW-P1W){prod_p1_q[P1W-1]}}, prod_p1_q};
    assign coef_x    = {{(PW-CW){1'b0}}, coef_p1_q};
    assign prod_p2   = p1_x * coef_x;
    assign scaled_p2 = prod_p2 >>> SHIFT;

    audio_sat_add #(.B_WIDTH(PW)) u_sat_add (
        .a_i (live_p1_q),
        .b_i (scaled_p2),
        .y_o (sum_p2)
    );

    assign bus.out       = out_p2_q;
    assign bus.out_valid = vld_p2_q;

endmodule

// File: tb/tb_loop_mixer.sv
// Directed bench for loop_mixer: reset, passthrough, fades, saturation, streaming, async reset.
module tb_loop_mixer;
    import audio_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    loop_mixer_if #(.GAIN_WIDTH(4)) bus ();

    loop_mixer #(.RAMP_BITS(4), .GAIN_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One isolated strobe; returns out_valid one clk later and out/out_valid two clks later.
    task automatic send(input int live, input int lp,
                        output sample_t o, output logic ov, output logic ov_early);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.live_in      = sample_t'(live);
        bus.loop_in      = sample_t'(lp);
        @(posedge clk); #1;
        ov_early = bus.out_valid;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(posedge clk); #1;
        o  = bus.out;
        ov = bus.out_valid;
    endtask

    task automatic test_reset();
        sample_t o; logic ov, ove;
        bus.sample_valid = 1'b1;
        bus.live_in      = sample_t'(1000);
        bus.loop_in      = sample_t'(1000);
        bus.loop_enable  = 1'b1;
        bus.loop_gain    = 4'd8;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out !== sample_t'(0)) begin
                failures++;
                $display("FAIL reset_hold[%0d] out=%0d out_valid=%b required out=0 out_valid=0",
                         i, bus.out, bus.out_valid);
            end
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.loop_enable  = 1'b0;
        reset            = 1'b1;
        send(1000, 5000, o, ov, ove);
        checks++;
        if (ove !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_early out_valid=%b required 0", ove);
        end
        checks++;
        if (ov !== 1'b1 || o !== sample_t'(1000)) begin
            failures++;
            $display("FAIL reset_first out=%0d out_valid=%b required out=1000 out_valid=1", o, ov);
        end
    endtask

    task automatic test_passthrough();
        sample_t o; logic ov, ove;
        bus.loop_enable = 1'b0;
        bus.loop_gain   = 4'd8;
        for (int i = 0; i < 4; i++) begin
            send(1000, 5000, o, ov, ove);
            checks++;
            if (ove !== 1'b0 || ov !== 1'b1 || o !== sample_t'(1000)) begin
                failures++;
                $display("FAIL passthrough[%0d] out=%0d valid_early=%b valid=%b required 1000/0/1",
                         i, o, ove, ov);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out !== sample_t'(1000)) begin
                failures++;
                $display("FAIL passthrough_hold[%0d] out=%0d out_valid=%b required 1000/0",
                         i, bus.out, bus.out_valid);
            end
        end
    endtask

    task automatic test_fade_in();
        sample_t o; logic ov, ove; int exp;
        bus.loop_enable = 1'b1;
        bus.loop_gain   = 4'd8;
        for (int i = 0; i < 18; i++) begin
            send(0, 1600, o, ov, ove);
            exp = (i < 16) ? 100 * i : 1600;
            checks++;
            if (ov !== 1'b1 || o !== sample_t'(exp)) begin
                failures++;
                $display("FAIL fade_in[%0d] out=%0d valid=%b required %0d", i, o, ov, exp);
            end
            if (i == 15) begin
                checks++;
                if (dut.state_q !== PLAY) begin
                    failures++;
                    $display("FAIL fade_in_play state=%0d required %0d", dut.state_q, PLAY);
                end
            end
        end
    endtask

    task automatic test_saturation();
        sample_t o; logic ov, ove;
        int lv[3]  = '{8000000, -8000000, 100};
        int lp[3]  = '{1000000, -1000000, -3};
        int ex[3]  = '{8388607, -8388608, 94};
        bus.loop_enable = 1'b1;
        bus.loop_gain   = 4'd15;
        for (int i = 0; i < 3; i++) begin
            send(lv[i], lp[i], o, ov, ove);
            checks++;
            if (ov !== 1'b1 || o !== sample_t'(ex[i])) begin
                failures++;
                $display("FAIL saturation[%0d] out=%0d valid=%b required %0d", i, o, ov, ex[i]);
            end
        end
    endtask

    task automatic test_gain_mute();
        sample_t o; logic ov, ove;
        bus.loop_gain = 4'd0;
        send(1234, 5000, o, ov, ove);
        checks++;
        if (ov !== 1'b1 || o !== sample_t'(1234)) begin
            failures++;
            $display("FAIL gain_mute out=%0d valid=%b required 1234", o, ov);
        end
        checks++;
        if (dut.state_q !== PLAY) begin
            failures++;
            $display("FAIL gain_mute_state state=%0d required %0d", dut.state_q, PLAY);
        end
    endtask

    task automatic test_reversal();
        sample_t o; logic ov, ove;
        int seq_en[22];
        int seq_ex[22];
        int k;
        bus.loop_gain   = 4'd8;
        bus.loop_enable = 1'b0;
        for (int i = 0; i < 16; i++) send(0, 1600, o, ov, ove);
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL drain_idle state=%0d required %0d", dut.state_q, IDLE);
        end
        // up 5, down 6 to zero, then up 3, down 2, up 3 again
        k = 0;
        for (int i = 0; i < 5; i++) begin seq_en[k] = 1; seq_ex[k] = 100 * i; k++; end
        for (int i = 0; i < 6; i++) begin seq_en[k] = 0; seq_ex[k] = 500 - 100 * i; k++; end
        for (int i = 0; i < 3; i++) begin seq_en[k] = 1; seq_ex[k] = 100 * i; k++; end
        seq_en[k] = 0; seq_ex[k] = 300; k++;
        seq_en[k] = 0; seq_ex[k] = 200; k++;
        for (int i = 0; i < 3; i++) begin seq_en[k] = 1; seq_ex[k] = 100 + 100 * i; k++; end
        for (int i = 0; i < 19; i++) begin
            bus.loop_enable = (seq_en[i] != 0);
            send(0, 1600, o, ov, ove);
            checks++;
            if (ov !== 1'b1 || o !== sample_t'(seq_ex[i])) begin
                failures++;
                $display("FAIL reversal[%0d] out=%0d valid=%b required %0d", i, o, ov, seq_ex[i]);
            end
            if (i == 10) begin
                checks++;
                if (dut.state_q !== IDLE) begin
                    failures++;
                    $display("FAIL reversal_idle state=%0d required %0d", dut.state_q, IDLE);
                end
            end
        end
        checks++;
        if (dut.state_q !== FADE_IN) begin
            failures++;
            $display("FAIL reenable_state state=%0d required %0d", dut.state_q, FADE_IN);
        end
    endtask

    task automatic test_back_to_back();
        sample_t o; logic ov, ove;
        int exp;
        bus.loop_enable = 1'b1;
        bus.loop_gain   = 4'd8;
        for (int i = 0; i < 14; i++) send(0, 1600, o, ov, ove);
        checks++;
        if (dut.state_q !== PLAY) begin
            failures++;
            $display("FAIL b2b_play state=%0d required %0d", dut.state_q, PLAY);
        end
        // In PLAY at unity gain the scaled loop equals the loop sample.
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c < 20) begin
                bus.sample_valid = 1'b1;
                bus.live_in      = sample_t'(c * 10);
                bus.loop_in      = sample_t'(c * 1000 - 7000);
            end else begin
                bus.sample_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (c >= 1 && c <= 20) begin
                exp = (c - 1) * 10 + (c - 1) * 1000 - 7000;
                if (bus.out_valid !== 1'b1 || bus.out !== sample_t'(exp)) begin
                    failures++;
                    $display("FAIL b2b[%0d] out=%0d valid=%b required %0d/1",
                             c - 1, bus.out, bus.out_valid, exp);
                end
            end else begin
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_edge[%0d] out_valid=%b required 0", c, bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        sample_t o; logic ov, ove;
        send(500, 1600, o, ov, ove);
        checks++;
        if (ov !== 1'b1 || o !== sample_t'(2100)) begin
            failures++;
            $display("FAIL play_mix out=%0d valid=%b required 2100", o, ov);
        end
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.live_in      = sample_t'(777);
        bus.loop_in      = sample_t'(0);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== sample_t'(777)) begin
            failures++;
            $display("FAIL pre_reset out=%0d valid=%b required 777/1", bus.out, bus.out_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== sample_t'(0)) begin
            failures++;
            $display("FAIL async_clear out=%0d valid=%b required 0/0", bus.out, bus.out_valid);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL async_state state=%0d required %0d", dut.state_q, IDLE);
        end
        @(negedge clk);
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobe out_valid=%b required 0", bus.out_valid);
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        reset            = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_release out_valid=%b required 0", bus.out_valid);
        end
        bus.loop_enable = 1'b1;
        bus.loop_gain   = 4'd8;
        for (int i = 0; i < 3; i++) begin
            send(0, 1600, o, ov, ove);
            checks++;
            if (ov !== 1'b1 || o !== sample_t'(100 * i)) begin
                failures++;
                $display("FAIL restart_ramp[%0d] out=%0d valid=%b required %0d", i, o, ov, 100 * i);
            end
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.live_in      = '0;
        bus.loop_in      = '0;
        bus.loop_enable  = 1'b0;
        bus.loop_gain    = '0;
        test_reset();
        test_passthrough();
        test_fade_in();
        test_saturation();
        test_gain_mute();
        test_reversal();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/loop_mixer.md
Name: loop_mixer

Overview:
Downstream stage of the audio looper. Per audio sample it mixes the live codec input with the looper playback and applies a scaled loop gain. A linear fade ramp on loop start/stop avoids clicks. The result is saturated to 24-bit signed, and the mixed sample feeds the codec output path.

Parameters:
DATA_WIDTH, 24, sample width, two's-complement signed
RAMP_BITS, 4, fade length = 2**RAMP_BITS samples; coefficient range 0..2**RAMP_BITS
GAIN_WIDTH, 4, loop gain width, unsigned; unity gain = 8 (units of 1/8)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
sample_valid  input  1  one-cycle strobe, one per audio sample; back-to-back strobes legal
live_in  input  DATA_WIDTH  live sample, signed
loop_in  input  DATA_WIDTH  looper playback sample, signed
loop_enable  input  1  request loop audible (level)
loop_gain  input  GAIN_WIDTH  loop gain, value/8
out  output  DATA_WIDTH  mixed sample, signed, held between valids
out_valid  output  1  one-cycle strobe, exactly 2 clk after the matching sample_valid

Behaviour:
- Reset (reset=0, async): out=0, out_valid=0, fade state IDLE, coef=0, pipeline valid bits cleared. No out_valid while reset is low.
- Fade FSM: states IDLE, FADE_IN, PLAY, FADE_OUT. The FSM is evaluated only on cycles with sample_valid=1 and holds otherwise.
  - IDLE: loop_enable=1 -> FADE_IN, coef+1. Otherwise stays, coef=0.
  - FADE_IN: loop_enable=0 -> FADE_OUT, coef-1. Otherwise coef+1; when the new coef equals 2**RAMP_BITS -> PLAY.
  - PLAY: loop_enable=0 -> FADE_OUT, coef-1. Otherwise stays, coef=max.
  - FADE_OUT: loop_enable=1 -> FADE_IN, coef+1. Otherwise coef-1; when the new coef equals 0 -> IDLE.
  - A reversal mid-fade continues from the current coef; there is no jump.
- Coefficient used for a sample: the registered coef before that strobe's update.
- Stage 1 (on sample_valid):
  - Register live_in and coef.
  - Register p1 = loop_in * loop_gain. loop_gain is zero-extended, giving a signed DATA_WIDTH+GAIN_WIDTH+1 result.
  - Set v1 = 1.
  - loop_gain and loop_in are sampled at the strobe only.
- Stage 2 (on v1):
  - scaled = (p1 * coef) >>> (RAMP_BITS+3), arithmetic shift (floor).
  - sum = live + scaled, computed at full width with no intermediate truncation.
  - out = sum clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
  - out_valid pulses for 1 cycle.
- loop_gain=0 mutes the loop regardless of FSM state. FSM and coef still advance.
- Latency: fixed 2 clk from sample_valid to out_valid; throughput 1 sample/clk.
- A loop_enable toggle between strobes is seen only at the next strobe; a pulse shorter than the strobe spacing can be missed. This is accepted.
- Async reset mid-fade or mid-PLAY: immediate clear. After release, the loop is silent until a new FADE_IN completes its ramp.

Decomposition:
- Package audio_pkg holds:
  - DATA_WIDTH
  - typedef sample_t (logic signed [DATA_WIDTH-1:0])
  - enum fade_state_t {IDLE, FADE_IN, PLAY, FADE_OUT}
  - constants SAMPLE_MAX/SAMPLE_MIN and GAIN_UNITY=8
- Sub-module audio_sat_add: combinational full-width signed add + clamp to sample_t. It is reused later by other mix stages.

Test Plan:
All scenarios use RAMP_BITS=4 and gain 8 (scaled = loop*coef/16) unless stated.
- Reset held low 3 clk with strobes applied -> out=0, out_valid=0 throughout. After release, first strobe yields out_valid exactly 2 clk later.
- loop_enable=0, live=1000, loop=5000, 4 strobes -> out=1000 each time, out_valid 2 clk after each strobe, out held between.
- Fade-in:
  - Stimulus: live=0, loop=1600, loop_enable rises before strobe 1.
  - Outputs 0,100,200,...,1500 for strobes 1-16, then 1600 from strobe 17 on.
  - FSM reaches PLAY after strobe 16.
- Saturation in PLAY, gain 15:
  - live=8,000,000, loop=1,000,000 (scaled 1,875,000) -> out=8,388,607.
  - live=-8,000,000, loop=-1,000,000 -> out=-8,388,608.
  - live=100, loop=-3 -> out=94 (floor of -5.625 = -6).
- Reversal:
  - Stimulus: fade-in with loop=1600 for 5 strobes (outputs 0..400), then loop_enable=0.
  - Outputs 500,400,300,200,100,0; FSM returns to IDLE.
  - Re-enable mid-fade-out resumes counting up from the current coef.
- Back-to-back strobes on 20 consecutive clk -> 20 consecutive out_valid, each sample correct with 2-clk latency.
- Async reset asserted mid-cycle during PLAY -> out=0 and out_valid=0 immediately.
  - After release: live=0, loop=1600, loop_enable=1 -> first output is 0, and the ramp restarts.
